// File: rtl/nios2_debug_ocimem_ctrl.sv
// Debug-slave on-chip memory controller: serves JTAG monitor commands and CPU
// Avalon-MM accesses against a shared single-port 256x32 debug RAM.
`timescale 1ns/1ps
module nios2_debug_ocimem_ctrl #(
  parameter int RAM_AW = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  input  logic [8:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic [3:0]  avs_byteenable,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  output logic [1:0]  dbg_state
);

  // Avalon handshake: a request is held until a cycle with waitrequest low,
  // in which it completes; read data is valid in that same cycle.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_JRD = 2'd1, S_CRD = 2'd2} state_t;

  localparam logic [8:0] STATUS_ADDR = 9'h100;

  state_t              state_q, state_d;
  logic [RAM_AW-1:0]   mon_a_q, mon_a_d;
  logic                jreq_q, jreq_d;
  logic                jreq_wr_q, jreq_wr_d;
  logic                jreq_seq_q, jreq_seq_d;
  logic [31:0]         jreq_wdata_q, jreq_wdata_d;
  logic                overrun_q, overrun_d;
  logic [31:0]         mon_d_q, mon_d_d;
  logic                ready_q, ready_d;
  logic                error_q, error_d;

  logic [31:0]         mem [2**RAM_AW];
  logic [31:0]         ram_rdata_q;
  logic [RAM_AW-1:0]   ram_addr;
  logic                ram_we;
  logic [3:0]          ram_be;
  logic [31:0]         ram_wdata;

  logic                strobe;
  logic                cpu_set_rdy, cpu_set_err, jtag_clr;
  logic                unused_jdo;

  assign strobe     = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  always_comb begin
    state_d      = state_q;
    mon_a_d      = mon_a_q;
    jreq_d       = jreq_q;
    jreq_wr_d    = jreq_wr_q;
    jreq_seq_d   = jreq_seq_q;
    jreq_wdata_d = jreq_wdata_q;
    overrun_d    = overrun_q;
    mon_d_d      = mon_d_q;
    ram_addr     = mon_a_q;
    ram_we       = 1'b0;
    ram_be       = 4'h0;
    ram_wdata    = jreq_wdata_q;
    cpu_set_rdy  = 1'b0;
    cpu_set_err  = 1'b0;
    jtag_clr     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (jreq_q) begin
          if (jreq_wr_q) begin
            ram_we  = 1'b1;
            ram_be  = 4'hF;
            jreq_d  = 1'b0;
            mon_a_d = mon_a_q + RAM_AW'(1);
          end else begin
            state_d = S_JRD;
          end
        end else if (avs_write) begin
          if (!avs_address[8]) begin
            ram_addr  = avs_address[RAM_AW-1:0];
            ram_we    = 1'b1;
            ram_be    = avs_byteenable;
            ram_wdata = avs_writedata;
          end else if (avs_address == STATUS_ADDR) begin
            cpu_set_rdy = avs_writedata[0];
            cpu_set_err = avs_writedata[1];
            if (avs_writedata[2]) overrun_d = 1'b0;
          end
        end else if (avs_read) begin
          ram_addr = avs_address[RAM_AW-1:0];
          state_d  = S_CRD;
        end
      end
      S_JRD: begin
        mon_d_d = ram_rdata_q;
        jreq_d  = 1'b0;
        if (jreq_seq_q) mon_a_d = mon_a_q + RAM_AW'(1);
        state_d = S_IDLE;
      end
      S_CRD:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Only one JTAG command may be outstanding; later strobes are discarded whole.
    if (strobe && jreq_q) begin
      overrun_d = 1'b1;
    end else if (take_action_ocimem_a) begin
      mon_a_d  = jdo[10 +: RAM_AW];
      jtag_clr = jdo[25];
      if (jdo[35]) begin
        jreq_d     = 1'b1;
        jreq_wr_d  = 1'b0;
        jreq_seq_d = 1'b0;
      end
    end else if (take_no_action_ocimem_a) begin
      if (jdo[35]) begin
        jreq_d     = 1'b1;
        jreq_wr_d  = 1'b0;
        jreq_seq_d = 1'b1;
      end
    end else if (take_action_ocimem_b) begin
      jreq_d       = 1'b1;
      jreq_wr_d    = 1'b1;
      jreq_seq_d   = 1'b0;
      jreq_wdata_d = jdo[34:3];
    end

    // A JTAG clear beats a CPU set landing on the same edge.
    ready_d = (ready_q | cpu_set_rdy) & ~jtag_clr;
    error_d = (error_q | cpu_set_err) & ~jtag_clr;
  end

  always_comb begin
    avs_readdata = 32'h0;
    if (state_q == S_CRD) begin
      if (!avs_address[8])                 avs_readdata = ram_rdata_q;
      else if (avs_address == STATUS_ADDR) avs_readdata = {29'b0, overrun_q, error_q, ready_q};
    end
    avs_waitrequest = (avs_read | avs_write)
                    && !(state_q == S_IDLE && !jreq_q && avs_write)
                    && (state_q != S_CRD);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      mon_a_q      <= '0;
      jreq_q       <= 1'b0;
      jreq_wr_q    <= 1'b0;
      jreq_seq_q   <= 1'b0;
      jreq_wdata_q <= 32'h0;
      overrun_q    <= 1'b0;
      mon_d_q      <= 32'h0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mon_a_q      <= mon_a_d;
      jreq_q       <= jreq_d;
      jreq_wr_q    <= jreq_wr_d;
      jreq_seq_q   <= jreq_seq_d;
      jreq_wdata_q <= jreq_wdata_d;
      overrun_q    <= overrun_d;
      mon_d_q      <= mon_d_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  // Debug RAM contents are deliberately not reset; writes are suppressed in reset.
  always_ff @(posedge clk) begin
    if (ram_we && reset_n) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_rdata_q <= mem[ram_addr];
  end

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Bench for nios2_debug_ocimem_ctrl: directed and random JTAG/CPU traffic,
// expected data queued from a behavioural model and checked by a monitor.
`timescale 1ns/1ps
module tb_nios2_debug_ocimem_ctrl;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
  logic [8:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  nios2_debug_ocimem_ctrl #(.RAM_AW(8)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(take_action_ocimem_a),
    .take_no_action_ocimem_a(take_no_action_ocimem_a),
    .take_action_ocimem_b(take_action_ocimem_b),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] jtag_exp_q[$];
  logic [31:0] cpu_exp_q[$];
  bit          mon_saw_jrd;

  // Reference model: RAM image, monitor address, flags.
  logic [31:0] m_mem [256];
  logic [7:0]  m_addr;
  bit          m_ready, m_error, m_overrun;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: output presented with no expected value queued", name);
  endtask

  // ---------------- monitor ----------------
  initial begin
    mon_saw_jrd = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_saw_jrd && reset_n) begin
        if (jtag_exp_q.size() == 0) fail_now("jtag_unexpected");
        else check("jtag_mondreg", MonDReg, jtag_exp_q.pop_front());
      end
      mon_saw_jrd = reset_n && (dbg_state == 2'd1);
      if (reset_n && avs_read && !avs_waitrequest) begin
        if (cpu_exp_q.size() == 0) fail_now("cpu_unexpected");
        else check("cpu_readdata", avs_readdata, cpu_exp_q.pop_front());
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  // kind: 0 = take_action_ocimem_a, 1 = take_no_action_ocimem_a, 2 = take_action_ocimem_b
  task automatic model_jtag(input int kind, input logic [37:0] j, input bit busy);
    if (busy) begin
      m_overrun = 1'b1;
    end else if (kind == 0) begin
      m_addr = j[17:10];
      if (j[25]) begin m_ready = 1'b0; m_error = 1'b0; end
      if (j[35]) jtag_exp_q.push_back(m_mem[m_addr]);
    end else if (kind == 1) begin
      if (j[35]) begin
        jtag_exp_q.push_back(m_mem[m_addr]);
        m_addr = m_addr + 8'd1;
      end
    end else begin
      m_mem[m_addr] = j[34:3];
      m_addr = m_addr + 8'd1;
    end
  endtask

  task automatic model_cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    if (!a[8]) begin
      for (int b = 0; b < 4; b++) if (be[b]) m_mem[a[7:0]][8*b +: 8] = d[8*b +: 8];
    end else if (a == 9'h100) begin
      if (d[0]) m_ready = 1'b1;
      if (d[1]) m_error = 1'b1;
      if (d[2]) m_overrun = 1'b0;
    end
  endtask

  function automatic logic [31:0] model_cpu_read(input logic [8:0] a);
    if (!a[8])         return m_mem[a[7:0]];
    if (a == 9'h100)   return {29'd0, m_overrun, m_error, m_ready};
    return 32'd0;
  endfunction

  function automatic logic [37:0] mk_a(input logic [7:0] addr, input bit rd, input bit clr);
    logic [37:0] j;
    j = 38'({$urandom, $urandom});
    j[17:10] = addr; j[35] = rd; j[25] = clr;
    return j;
  endfunction

  function automatic logic [37:0] mk_na(input bit rd);
    logic [37:0] j;
    j = 38'({$urandom, $urandom});
    j[35] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = 38'({$urandom, $urandom});
    j[34:3] = d;
    return j;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic jtag_cmd(input int kind, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a    = (kind == 0);
    take_no_action_ocimem_a = (kind == 1);
    take_action_ocimem_b    = (kind == 2);
    tick();
    take_action_ocimem_a    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b    = 1'b0;
  endtask

  task automatic jtag_op(input int kind, input logic [37:0] j);
    model_jtag(kind, j, 1'b0);
    jtag_cmd(kind, j);
    repeat (3) tick();
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be,
                           output int waits);
    bit done = 1'b0;
    waits = 0;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    while (!done && waits < 20) begin
      @(negedge clk);
      if (!avs_waitrequest) done = 1'b1;
      else waits++;
      @(posedge clk); #1;
    end
    avs_write = 1'b0;
    if (!done) check("cpu_write_timeout", 32'(done), 32'd1);
    else model_cpu_write(a, d, be);
  endtask

  task automatic cpu_read(input logic [8:0] a, output int waits);
    bit done = 1'b0;
    waits = 0;
    cpu_exp_q.push_back(model_cpu_read(a));
    avs_address = a; avs_read = 1'b1;
    while (!done && waits < 20) begin
      @(negedge clk);
      if (!avs_waitrequest) done = 1'b1;
      else waits++;
      @(posedge clk); #1;
    end
    avs_read = 1'b0;
    if (!done) check("cpu_read_timeout", 32'(done), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int bad_w;
    int bad_r;
    logic [37:0] j, j2;

    reset_n = 1'b0; jdo = '0;
    take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0; avs_byteenable = '0;
    m_addr = 8'd0; m_ready = 1'b0; m_error = 1'b0; m_overrun = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    check("rst_mondreg",     MonDReg, 32'd0);
    check("rst_readdata",    avs_readdata, 32'd0);
    check("rst_ready",       32'(monitor_ready), 32'd0);
    check("rst_error",       32'(monitor_error), 32'd0);
    check("rst_waitrequest", 32'(avs_waitrequest), 32'd0);
    check("rst_state_idle",  32'(dbg_state), 32'd0);

    // Fill the RAM so every model entry is known.
    bad_w = 0;
    for (int a = 0; a < 256; a++) begin
      cpu_write(9'(a), $urandom, 4'hF, w);
      if (w != 0) bad_w++;
    end
    check("init_write_waits", 32'(bad_w), 32'd0);

    // JTAG read with latency check, address held after a non-sequential read.
    cpu_write(9'h010, 32'hDEADBEEF, 4'hF, w);
    check("cpu_write_zero_wait", 32'(w), 32'd0);
    j = mk_a(8'h10, 1'b1, 1'b0);
    model_jtag(0, j, 1'b0);
    jtag_cmd(0, j);
    tick();
    check("jtag_rd_not_early", MonDReg, 32'd0);
    tick();
    check("jtag_rd_latency", MonDReg, 32'hDEADBEEF);
    tick();
    jtag_op(1, mk_na(1'b1));
    jtag_op(1, mk_na(1'b1));

    // JTAG writes wrapping 0xFF -> 0x00, then sequential reads.
    jtag_op(0, mk_a(8'hFF, 1'b0, 1'b0));
    jtag_op(2, mk_b(32'h12345678));
    jtag_op(2, mk_b(32'h9ABCDEF0));
    check("model_wrap_ff", m_mem[8'hFF], 32'h12345678);
    check("model_wrap_00", m_mem[8'h00], 32'h9ABCDEF0);
    cpu_read(9'h0FF, w);
    cpu_read(9'h000, w);
    check("cpu_read_one_wait", 32'(w), 32'd1);
    jtag_op(0, mk_a(8'hFF, 1'b0, 1'b0));
    jtag_op(1, mk_na(1'b1));
    jtag_op(1, mk_na(1'b1));

    // Contention: CPU read while a JTAG read is pending.
    j = mk_a(8'h30, 1'b1, 1'b0);
    model_jtag(0, j, 1'b0);
    jtag_cmd(0, j);
    cpu_read(9'h020, w);
    check("contention_waits_ge2", 32'(w >= 2), 32'd1);
    check("contention_jtag_first", MonDReg, m_mem[8'h30]);
    tick();

    // Handshake flags.
    cpu_write(9'h100, 32'h3, 4'hF, w);
    check("flag_set_ready", 32'(monitor_ready), 32'd1);
    check("flag_set_error", 32'(monitor_error), 32'd1);
    cpu_read(9'h100, w);
    jtag_op(0, mk_a(8'h00, 1'b0, 1'b1));
    check("flag_clr_ready", 32'(monitor_ready), 32'd0);
    check("flag_clr_error", 32'(monitor_error), 32'd0);
    j = mk_a(8'h05, 1'b0, 1'b1);
    avs_address = 9'h100; avs_writedata = 32'h3; avs_byteenable = 4'hF; avs_write = 1'b1;
    jdo = j; take_action_ocimem_a = 1'b1;
    @(negedge clk);
    check("same_cycle_accept", 32'(avs_waitrequest), 32'd0);
    tick();
    avs_write = 1'b0; take_action_ocimem_a = 1'b0;
    model_cpu_write(9'h100, 32'h3, 4'hF);
    model_jtag(0, j, 1'b0);
    check("same_cycle_ready", 32'(monitor_ready), 32'(m_ready));
    check("same_cycle_error", 32'(monitor_error), 32'(m_error));
    cpu_write(9'h1A5, 32'h7, 4'hF, w);
    cpu_read(9'h100, w);
    cpu_read(9'h137, w);

    // Overrun: second strobe while the first is pending is discarded entirely.
    j  = mk_a(8'h40, 1'b1, 1'b0);
    j2 = mk_a(8'h50, 1'b1, 1'b0);
    model_jtag(0, j, 1'b0);
    jtag_cmd(0, j);
    model_jtag(0, j2, 1'b1);
    jtag_cmd(0, j2);
    repeat (3) tick();
    cpu_read(9'h100, w);
    jtag_op(1, mk_na(1'b1));
    cpu_write(9'h100, 32'h4, 4'hF, w);
    cpu_read(9'h100, w);

    // Byte-enable merge.
    cpu_write(9'h060, 32'hAABBCCDD, 4'b0010, w);
    cpu_read(9'h060, w);
    jtag_op(0, mk_a(8'h60, 1'b1, 1'b0));

    // Random mixed traffic.
    bad_w = 0; bad_r = 0;
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 6))
        0: begin
          cpu_write({1'b0, 8'($urandom_range(0, 255))}, $urandom, 4'($urandom_range(0, 15)), w);
          if (w != 0) bad_w++;
        end
        1: begin
          cpu_read({1'b0, 8'($urandom_range(0, 255))}, w);
          if (w != 1) bad_r++;
        end
        2: jtag_op(0, mk_a(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1))));
        3: jtag_op(1, mk_na(1'($urandom_range(0, 1))));
        4: jtag_op(2, mk_b($urandom));
        5: cpu_write(9'h100, 32'($urandom_range(0, 7)), 4'hF, w);
        default: cpu_read(9'($urandom_range(256, 511)), w);
      endcase
    end
    check("rand_write_waits", 32'(bad_w), 32'd0);
    check("rand_read_waits",  32'(bad_r), 32'd0);

    // Reset during JRD: pending read discarded, no MonDReg update.
    cpu_write(9'h100, 32'h3, 4'hF, w);
    jtag_cmd(0, mk_a(8'h70, 1'b1, 1'b0));
    tick();
    check("pre_reset_in_jrd", 32'(dbg_state), 32'd1);
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    m_addr = 8'd0; m_ready = 1'b0; m_error = 1'b0; m_overrun = 1'b0;
    repeat (3) tick();
    check("mid_reset_mondreg", MonDReg, 32'd0);
    check("mid_reset_state",   32'(dbg_state), 32'd0);
    check("mid_reset_ready",   32'(monitor_ready), 32'd0);
    cpu_write(9'h0A0, 32'h0BADF00D, 4'hF, w);
    check("mid_reset_no_pending", 32'(w), 32'd0);
    cpu_read(9'h100, w);
    jtag_op(1, mk_na(1'b1));

    repeat (3) tick();
    check("jtag_queue_drained", 32'(jtag_exp_q.size()), 32'd0);
    check("cpu_queue_drained",  32'(cpu_exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
